// File: rtl/game_timer.sv
// Parametrised game timer: up/down counting, runtime load, start/pause, one-shot or auto-reload.
// Optional step prescaler is compiled in when GAME_TIMER_PRESCALE_EN is defined.
module game_timer #(
  parameter int unsigned      WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
  parameter int unsigned      MAX_VAL   = 2**WIDTH - 1,
  parameter int unsigned      PRESCALE  = 1
) (
  input  logic             clk_4_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             mode_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] count_o,
  output logic             running_o,
  output logic             expired_o,
  output logic             tc_pulse_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StPause   = 2'd2;
  localparam logic [1:0] StExpired = 2'd3;

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  logic [WIDTH-1:0] load_clamped;
  logic             at_term;
  logic             run_active;
  logic             presc_hit;
  logic             step;

  assign load_clamped = (load_val_i > MaxVal) ? MaxVal : load_val_i;

  // Counting up treats anything at or above MaxVal as terminal so a count parked above
  // MaxVal (e.g. a larger reset value) can never wrap through the all-ones value.
  assign at_term = dir_i ? (count_q >= MaxVal) : (count_q == '0);

  // A RUN cycle only advances when no higher-priority control is present.
  assign run_active = (state_q == StRun) && !load_i && !pause_i;
  assign step       = run_active && presc_hit;
  assign tc_pulse_o = step && at_term;

`ifdef GAME_TIMER_PRESCALE_EN
  localparam int unsigned PresW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(PRESCALE - 1);

  logic [PresW-1:0] presc_q, presc_d;

  assign presc_hit = (presc_q == PresMax);

  always_comb begin
    presc_d = presc_q;
    if (load_i) begin
      presc_d = '0;
    end else begin
      case (state_q)
        StIdle, StExpired: begin
          if (start_i) begin
            presc_d = '0;
          end
        end
        StRun: begin
          if (run_active) begin
            presc_d = presc_hit ? '0 : presc_q + 1'b1;
          end
        end
        default: presc_d = presc_q;
      endcase
    end
  end

  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign presc_hit = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    if (load_i) begin
      count_d  = load_clamped;
      reload_d = load_clamped;
      state_d  = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (pause_i) begin
            state_d = StPause;
          end else if (step) begin
            if (at_term) begin
              if (mode_i) begin
                count_d = reload_q;
              end else begin
                state_d = StExpired;
              end
            end else if (dir_i) begin
              count_d = count_q + 1'b1;
            end else begin
              count_d = count_q - 1'b1;
            end
          end
        end
        StPause: begin
          if (start_i) begin
            state_d = StRun;
          end
        end
        StExpired: begin
          if (start_i) begin
            count_d = reload_q;
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_4_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      count_q  <= RESET_VAL;
      reload_q <= RESET_VAL;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign count_o   = count_q;
  assign running_o = (state_q == StRun);
  assign expired_o = (state_q == StExpired);

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: behavioural model compared every cycle plus
// directed literal checks. Also exercises a MAX_VAL = 20 instance for load clamping.
module tb_game_timer;

`ifdef GAME_TIMER_PRESCALE_EN
  localparam int PRE = 4;
`else
  localparam int PRE = 1;
`endif
  localparam int W    = 5;
  localparam int MAXV = 31;
  localparam int RV   = 31;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         mode = 1'b0;
  logic         dir = 1'b0;

  logic [W-1:0] count_o, count2_o;
  logic         running_o, running2_o;
  logic         expired_o, expired2_o;
  logic         tc_o, tc2_o;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  game_timer #(.WIDTH(W), .PRESCALE(PRE)) dut (
    .clk_4_i(clk), .rst_i(rst), .load_i(load), .load_val_i(load_val), .start_i(start),
    .pause_i(pause), .mode_i(mode), .dir_i(dir), .count_o(count_o), .running_o(running_o),
    .expired_o(expired_o), .tc_pulse_o(tc_o)
  );

  game_timer #(.WIDTH(W), .MAX_VAL(20), .PRESCALE(PRE)) dut2 (
    .clk_4_i(clk), .rst_i(rst), .load_i(load), .load_val_i(load_val), .start_i(start),
    .pause_i(pause), .mode_i(mode), .dir_i(dir), .count_o(count2_o), .running_o(running2_o),
    .expired_o(expired2_o), .tc_pulse_o(tc2_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 run, 2 paused, 3 expired; counts kept as plain integers.
  int m_count  = RV;
  int m_reload = RV;
  int m_pc     = 0;
  int m_phase  = 0;

  function automatic bit m_step();
    return (m_phase == 1) && !load && !pause && (m_pc == PRE - 1);
  endfunction

  function automatic bit m_tc();
    return m_step() && (m_count == (dir ? MAXV : 0));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count  <= RV;
      m_reload <= RV;
      m_pc     <= 0;
      m_phase  <= 0;
    end else if (load) begin
      m_count  <= (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_reload <= (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_pc     <= 0;
      m_phase  <= 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
        m_pc    <= 0;
      end
    end else if (m_phase == 1) begin
      if (pause) begin
        m_phase <= 2;
      end else if (m_pc != PRE - 1) begin
        m_pc <= m_pc + 1;
      end else begin
        m_pc <= 0;
        if (m_tc()) begin
          if (mode) m_count <= m_reload;
          else m_phase <= 3;
        end else begin
          m_count <= dir ? m_count + 1 : m_count - 1;
        end
      end
    end else if (m_phase == 2) begin
      if (start) m_phase <= 1;
    end else begin
      if (start) begin
        m_count <= m_reload;
        m_phase <= 1;
        m_pc    <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_count", 32'(count_o), m_count);
    chk("model_running", 32'(running_o), 32'(m_phase == 1));
    chk("model_expired", 32'(expired_o), 32'(m_phase == 3));
    chk("model_tc", 32'(tc_o), 32'(m_tc()));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int exp2[8] = '{3, 2, 1, 0, 3, 2, 1, 0};
  int exp3[4] = '{28, 29, 30, 31};

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_count", 32'(count_o), 31);
    chk("rst_running", 32'(running_o), 0);
    chk("rst_expired", 32'(expired_o), 0);
    chk("rst_tc", 32'(tc_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: free countdown to expiry
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t1_start_count", 32'(count_o), 31);
    chk("t1_start_running", 32'(running_o), 1);
    tick(31 * PRE + PRE - 1);
    chk("t1_zero_count", 32'(count_o), 0);
    chk("t1_tc", 32'(tc_o), 1);
    tick(1);
    chk("t1_expired", 32'(expired_o), 1);
    chk("t1_exp_running", 32'(running_o), 0);
    chk("t1_exp_tc", 32'(tc_o), 0);
    tick(5);
    chk("t1_hold_count", 32'(count_o), 0);
    chk("t1_hold_expired", 32'(expired_o), 1);

    // 2: auto-reload down from 3
    load = 1'b1; load_val = 5'd3; mode = 1'b1; dir = 1'b0;
    tick(1);
    load = 1'b0;
    chk("t2_load_count", 32'(count_o), 3);
    chk("t2_load_running", 32'(running_o), 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(PRE - 1);
      chk("t2_count", 32'(count_o), exp2[i]);
      chk("t2_tc", 32'(tc_o), 32'(exp2[i] == 0));
      chk("t2_running", 32'(running_o), 1);
      tick(1);
    end
    chk("t2_end_count", 32'(count_o), 3);

    // 3: one-shot up from 28, then restart from reload
    load = 1'b1; load_val = 5'd28; mode = 1'b0; dir = 1'b1;
    tick(1);
    load = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(PRE - 1);
      chk("t3_count", 32'(count_o), exp3[i]);
      chk("t3_tc", 32'(tc_o), 32'(exp3[i] == 31));
      tick(1);
    end
    chk("t3_expired", 32'(expired_o), 1);
    chk("t3_exp_count", 32'(count_o), 31);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t3_restart_count", 32'(count_o), 28);
    chk("t3_restart_running", 32'(running_o), 1);

    // 4: pause and resume
    dir = 1'b0; load = 1'b1; load_val = 5'd10;
    tick(1);
    load = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2 * PRE);
    chk("t4_run_count", 32'(count_o), 8);
    pause = 1'b1;
    tick(5);
    pause = 1'b0;
    chk("t4_pause_count", 32'(count_o), 8);
    chk("t4_pause_running", 32'(running_o), 0);
    tick(2);
    chk("t4_pause_hold", 32'(count_o), 8);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t4_resume_count", 32'(count_o), 8);
    chk("t4_resume_running", 32'(running_o), 1);
    tick(PRE);
    chk("t4_step1", 32'(count_o), 7);
    tick(PRE);
    chk("t4_step2", 32'(count_o), 6);

    // 5: load beats start; load clamping on MAX_VAL = 20 instance
    load = 1'b1; load_val = 5'd12; start = 1'b1;
    tick(1);
    load = 1'b0; start = 1'b0;
    chk("t5_count", 32'(count_o), 12);
    chk("t5_running", 32'(running_o), 0);
    chk("t5_expired", 32'(expired_o), 0);
    tick(3);
    chk("t5_idle_hold", 32'(count_o), 12);
    load = 1'b1; load_val = 5'd25;
    tick(1);
    load = 1'b0;
    chk("t5_full_count", 32'(count_o), 25);
    chk("t5_clamp_count", 32'(count2_o), 20);
    dir = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(PRE - 1);
    chk("t5_clamp_tc", 32'(tc2_o), 1);
    chk("t5_clamp_hold", 32'(count2_o), 20);
    tick(1);
    chk("t5_clamp_expired", 32'(expired2_o), 1);
    chk("t5_clamp_exp_count", 32'(count2_o), 20);
    chk("t5_full_step", 32'(count_o), 26);

    // 6: asynchronous reset mid-run
    dir = 1'b0; load = 1'b1; load_val = 5'd20;
    tick(1);
    load = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3 * PRE);
    chk("t6_pre_count", 32'(count_o), 17);
    chk("t6_pre_running", 32'(running_o), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_count", 32'(count_o), 31);
    chk("t6_async_running", 32'(running_o), 0);
    chk("t6_async_tc", 32'(tc_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);
    chk("t6_post_count", 32'(count_o), 31);
    chk("t6_post_running", 32'(running_o), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
